cla_serial_add_ctrl: RTL and testbench
======================================

# cla_serial_add_ctrl

Multi-cycle sequencer that computes a WIDTH-bit addition by reusing one 4-bit carry-lookahead slice, one nibble per clock, least-significant nibble first. It sits between an operand producer and a result consumer in the adder subsystem, with valid/ready handshakes on both sides. Use it where area matters more than latency and a full-width carry-select or lookahead adder is too large.

## Interface
- WIDTH, 16: operand and sum width in bits; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents operands.
- in_ready  out  1  block can accept operands; equals 1 only in IDLE.
- a, b  in  WIDTH  operands; sampled only on accept.
- cin  in  1  carry-in; sampled only on accept.
- out_valid  out  1  result available; equals 1 only in DONE.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  registered sum.
- cout  out  1  registered carry-out of the MSB.
- busy  out  1  1 in RUN or DONE.
- ovf  out  1  signed overflow; present only with CLA_SERIAL_OVF_EN.

## Operation
- Internal 4-bit slice, per nibble k:
  - p = a_r[4k+3:4k] ^ b_r[4k+3:4k]
  - g = a_r[4k+3:4k] & b_r[4k+3:4k]
  - lookahead carries c1..c4 from p, g and carry_r
  - nibble sum = p ^ {c3,c2,c1,carry_r}
- State machine:
  - IDLE: in_ready=1. On accept (in_valid & in_ready): latch a_r←a, b_r←b, carry_r←cin, k←0, sum←0. Go to RUN.
  - RUN: each cycle write sum[4k+3:4k] and set carry_r←c4. If k==NIB-1: set cout←c4 and go to DONE; otherwise k←k+1.
  - DONE: out_valid=1. When out_ready=1, go to IDLE on the next edge.
- in_valid during RUN or DONE is ignored; the producer keeps its request pending.
- sum, cout and ovf hold stable from entering DONE until the next accept. They also stay readable in IDLE.
- No same-cycle turnaround: in DONE, in_ready=0, so a new accept happens no earlier than the cycle after the result handshake.
- Counter k is ceil(log2(NIB)) bits wide (minimum 1) and never wraps past NIB-1.

## Timing
- Reset values (asynchronous, on rst_n=0):
  - state IDLE, in_ready=1
  - out_valid=0, busy=0, sum=0, cout=0, ovf=0
  - k=0, carry_r=0, a_r=0, b_r=0
- Reset in the middle of RUN or DONE aborts the operation immediately; the partial result is discarded.
- Latency: accept on edge T0 → out_valid=1 after edge T0+NIB (e.g. 4 cycles for WIDTH=16).
- Throughput with out_ready held 1: one result per NIB+2 cycles.
- out_valid and in_ready are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Configuration
- CLA_SERIAL_OVF_EN defined:
  - ovf port exists.
  - On the final RUN cycle, ovf←c4 ^ c3 of the top nibble (carry into the MSB XOR carry out of the MSB).
  - ovf is reset to 0 and cleared on each accept.
- Not defined: ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0xFFFF, cin=1 → sum=0x0000, cout=1.
- With CLA_SERIAL_OVF_EN: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum and cout stay stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready gives in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 at k=2 → all outputs return to reset values immediately. After release, a new operation 0x00FF+0x0001 → sum=0x0100, cout=0.
- Back-to-back with in_valid and out_ready held 1, random a/b/cin × 100 → each result matches a+b+cin (WIDTH+1 bits), one result per 6 cycles.

Source files
------------

// File: rtl/cla_serial_add_ctrl_if.sv
// Handshake and data bundle for the nibble-serial CLA adder.
// The ovf signal exists only when CLA_SERIAL_OVF_EN is defined.
interface cla_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CLA_SERIAL_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CLA_SERIAL_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit adder reusing one 4-bit lookahead slice, LSB nibble first.
// Define CLA_SERIAL_OVF_EN to add the signed-overflow output.
module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    cla_serial_add_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_r;
    logic             cout_r;
    logic [3:0]       an;
    logic [3:0]       bn;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [3:0]       ns;
    logic             c1, c2, c3, c4;
    logic             last;
    logic             accept;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf_r;
`endif

    always_comb begin
        an = '0;
        bn = '0;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                an = a_r[4*i +: 4];
                bn = b_r[4*i +: 4];
            end
        end
    end

    assign p  = an ^ bn;
    assign g  = an & bn;
    assign c1 = g[0] | (p[0] & carry_r);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_r);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_r);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_r);
    assign ns = p ^ {c3, c2, c1, carry_r};

    always_comb begin
        sum_nxt = sum_r;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) sum_nxt[4*i +: 4] = ns;
        end
    end

    assign last   = (k == KW'(NIB - 1));
    assign accept = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.cin;
                        k       <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
                        ovf_r   <= 1'b0;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_r   <= sum_nxt;
                    carry_r <= c4;
                    if (last) begin
                        cout_r <= c4;
`ifdef CLA_SERIAL_OVF_EN
                        ovf_r  <= c4 ^ c3;
`endif
                        state  <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // handshake flags come from state only, no input-to-output path
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef CLA_SERIAL_OVF_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed and random checks for cla_serial_add_ctrl (WIDTH=16),
// with a queue of expected results popped as the DUT completes.
module tb_cla_serial_add_ctrl;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t q[$];

    cla_serial_add_ctrl_if #(.WIDTH(16)) bus ();

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
        exp_t e;
        logic [16:0] full;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.s = full[15:0];
        e.c = full[16];
        e.o = (a[15] == b[15]) && (full[15] != a[15]);
        q.push_back(e);
    endtask

    task automatic cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, ".sum"}, {15'd0, bus.cout, bus.sum}, {15'd0, e.c, e.s});
`ifdef CLA_SERIAL_OVF_EN
        chk({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, e.o});
`endif
    endtask

    // accept one operand set and wait for the result
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input string tag);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        push(a, b, cin);
        step();
        bus.in_valid = 1'b0;
        chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, n, 32'd4);
        cmp(tag);
    endtask

    task automatic release_op(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, ".idle_ov"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        logic [16:0] held;
        int cyc;
        int got;
        int sent;
        int lastc;
        bit acc;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        step();
        step();
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.sum", {15'd0, bus.cout, bus.sum}, 32'd0);
`ifdef CLA_SERIAL_OVF_EN
        chk("rst.ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        do_op(16'h1234, 16'h4321, 1'b0, "basic");
        chk("basic.const", {15'd0, bus.cout, bus.sum}, 32'h05555);
        release_op("basic");
        chk("basic.hold", {15'd0, bus.cout, bus.sum}, 32'h05555);

        do_op(16'hFFFF, 16'h0001, 1'b0, "wrap");
        chk("wrap.const", {15'd0, bus.cout, bus.sum}, 32'h10000);
        release_op("wrap");
        do_op(16'h0000, 16'hFFFF, 1'b1, "cin");
        chk("cin.const", {15'd0, bus.cout, bus.sum}, 32'h10000);
        release_op("cin");
`ifdef CLA_SERIAL_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
        chk("ovf_pos.const", {31'd0, bus.ovf}, 32'd1);
        release_op("ovf_pos");
        do_op(16'h8000, 16'h8000, 1'b0, "ovf_neg");
        chk("ovf_neg.const", {31'd0, bus.ovf}, 32'd1);
        release_op("ovf_neg");
`endif

        // backpressure with stray in_valid pulses
        do_op(16'hA5A5, 16'h1111, 1'b1, "bp");
        held = {bus.cout, bus.sum};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a = 16'h0F0F;
            bus.b = 16'hF0F0;
            step();
            chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp.sum", {15'd0, bus.cout, bus.sum}, {15'd0, held});
        end
        bus.in_valid = 1'b0;
        release_op("bp");
        chk("bp.after", {15'd0, bus.cout, bus.sum}, {15'd0, held});

        // reset while k==2
        bus.a        = 16'h1234;
        bus.b        = 16'h4321;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("mid.partial", {16'd0, bus.sum}, 32'h0055);
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid.busy", {31'd0, bus.busy}, 32'd0);
        chk("mid.sum", {15'd0, bus.cout, bus.sum}, 32'd0);
`ifdef CLA_SERIAL_OVF_EN
        chk("mid.ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        do_op(16'h00FF, 16'h0001, 1'b0, "post");
        chk("post.const", {15'd0, bus.cout, bus.sum}, 32'h00100);
        release_op("post");

        // streaming with both handshakes held high
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        bus.cin       = 1'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc   = 0;
        got   = 0;
        sent  = 0;
        lastc = 0;
        while (got < 100 && cyc < 2000) begin
            acc = bus.in_ready && bus.in_valid;
            if (acc) begin
                push(bus.a, bus.b, bus.cin);
                sent++;
            end
            if (bus.out_valid) begin
                cmp("b2b");
                if (got > 0) chk("b2b.period", cyc - lastc, 32'd6);
                lastc = cyc;
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                bus.a   = 16'($urandom);
                bus.b   = 16'($urandom);
                bus.cin = 1'($urandom);
                if (sent == 100) bus.in_valid = 1'b0;
            end
        end
        chk("b2b.count", got, 32'd100);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
